// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 LCD register consumer: FSM states,
// register bit positions and the long-execution command decode.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    WAIT  = 3'd4
  } lcd_state_e;

  localparam int LCD_ON_BIT   = 31;
  localparam int LCD_BLON_BIT = 30;
  localparam int LCD_REQ_BIT  = 10;
  localparam int LCD_RS_BIT   = 8;
  localparam int LCD_DATA_MSB = 7;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Clear (0x01) and both home encodings (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    logic hit;
    hit = (data == CMD_CLEAR) || ((data | 8'h01) == (CMD_HOME | 8'h01));
    return (rs == 1'b0) && hit;
  endfunction

endpackage

// File: rtl/lcd_ctrl.sv
// Drives an HD44780 character LCD from the memory-mapped LCD register word;
// each REQ toggle produces one setup / EN pulse / hold / execution-wait write.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int T_SETUP     = 2,
  parameter int T_PULSE     = 12,
  parameter int T_HOLD      = 1,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000,
  parameter int CNT_W       = 17
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] lcd_reg_i,
  output logic [7:0]  lcd_data_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic        lcd_on_o,
  output logic        lcd_blon_o,
  output logic        busy_o
);

  localparam logic [CNT_W-1:0] LD_SETUP     = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PULSE     = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_HOLD      = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_EXEC      = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] LD_EXEC_LONG = CNT_W'(T_EXEC_LONG - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             req_seen_q, req_seen_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;

  logic             pending_s;
  logic             timer_zero_s;
  logic             unused_reg_bits_s;

  assign pending_s         = (lcd_reg_i[LCD_REQ_BIT] != req_seen_q);
  assign timer_zero_s      = (timer_q == CNT_ZERO);
  assign unused_reg_bits_s = ^{lcd_reg_i[29:11], lcd_reg_i[9]};

  // Next-state, timer and output-register computation for the write sequencer.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    req_seen_d = req_seen_q;
    data_d     = data_q;
    rs_d       = rs_q;
    busy_d     = busy_q;
    en_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (pending_s) begin
          data_d     = lcd_reg_i[LCD_DATA_MSB:0];
          rs_d       = lcd_reg_i[LCD_RS_BIT];
          req_seen_d = lcd_reg_i[LCD_REQ_BIT];
          busy_d     = 1'b1;
          timer_d    = LD_SETUP;
          state_d    = SETUP;
        end else begin
          busy_d = 1'b0;
        end
      end
      SETUP: begin
        if (timer_zero_s) begin
          timer_d = LD_PULSE;
          state_d = PULSE;
          en_d    = 1'b1;
        end else begin
          timer_d = timer_q - CNT_ONE;
        end
      end
      PULSE: begin
        if (timer_zero_s) begin
          timer_d = LD_HOLD;
          state_d = HOLD;
        end else begin
          timer_d = timer_q - CNT_ONE;
          en_d    = 1'b1;
        end
      end
      HOLD: begin
        if (timer_zero_s) begin
          timer_d = is_long_cmd(rs_q, data_q) ? LD_EXEC_LONG : LD_EXEC;
          state_d = WAIT;
        end else begin
          timer_d = timer_q - CNT_ONE;
        end
      end
      WAIT: begin
        if (timer_zero_s) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = CNT_ZERO;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, timer and registered pad outputs; EN clears asynchronously on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      timer_q    <= CNT_ZERO;
      req_seen_q <= 1'b0;
      data_q     <= 8'h00;
      rs_q       <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      req_seen_q <= req_seen_d;
      data_q     <= data_d;
      rs_q       <= rs_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
    end
  end

  assign lcd_data_o = data_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_rw_o   = 1'b0;
  assign lcd_en_o   = en_q;
  assign busy_o     = busy_q;
  assign lcd_on_o   = lcd_reg_i[LCD_ON_BIT];
  assign lcd_blon_o = lcd_reg_i[LCD_BLON_BIT];

endmodule
